// File: rtl/machine_irq_ctrl.sv
// Machine-mode interrupt source: mtime/mtimecmp/msip on the data bus, held trap request.
// Optional external interrupt input enabled by defining MACHINE_IRQ_EXT_EN.
module machine_irq_ctrl #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_en_i,
  input  logic        bus_we_i,
  input  logic [4:0]  bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic [31:0] bus_rdata_o,
  output logic        bus_ready_o,
  input  logic        mie_global_i,
  input  logic [31:0] mie_i,
  input  logic        irq_ack_i,
`ifdef MACHINE_IRQ_EXT_EN
  input  logic        ext_irq_i,
`endif
  output logic        interrupt_o,
  output logic [31:0] irq_cause_o
);

  // state    | meaning
  // IDLE     | no request, watching the enabled set
  // REQ      | interrupt held high, cause frozen until ack or withdrawal
  // WAIT_CLR | trap taken, waiting for MIE drop or source clear before re-arming
  typedef enum logic [1:0] {IDLE, REQ, WAIT_CLR} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        mtip_q, mtip_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q;

  logic        wr;
  logic [2:0]  word;
  logic        tick;
  logic        meip;
  logic [31:0] mip;
  logic [31:0] en_set;
  logic [4:0]  src_idx;
  logic        unused_ok;

`ifdef MACHINE_IRQ_EXT_EN
  logic ext_s1_q, ext_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_s1_q <= 1'b0;
      ext_s2_q <= 1'b0;
    end else begin
      ext_s1_q <= ext_irq_i;
      ext_s2_q <= ext_s1_q;
    end
  end

  assign meip = ext_s2_q;
`else
  assign meip = 1'b0;
`endif

  assign wr        = bus_en_i & bus_we_i;
  assign word      = bus_addr_i[4:2];
  assign tick      = (presc_q == PRESC_MAX);
  assign src_idx   = cause_q[4:0];
  assign unused_ok = ^{bus_addr_i[1:0], mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  always_comb begin
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    // A bus write to either mtime half swallows the coincident tick.
    if (wr && word == 3'd3)      mtime_d[31:0]  = bus_wdata_i;
    else if (wr && word == 3'd4) mtime_d[63:32] = bus_wdata_i;
    else if (tick)               mtime_d        = mtime_q + 64'd1;
    if (wr && word == 3'd1) mtimecmp_d[31:0]  = bus_wdata_i;
    if (wr && word == 3'd2) mtimecmp_d[63:32] = bus_wdata_i;
    if (wr && word == 3'd0) msip_d = bus_wdata_i[0];
    mtip_d = (mtime_q >= mtimecmp_q);
  end

  always_comb begin
    rdata_d = '0;
    if (bus_en_i && !bus_we_i) begin
      case (word)
        3'd0:    rdata_d = {31'b0, msip_q};
        3'd1:    rdata_d = mtimecmp_q[31:0];
        3'd2:    rdata_d = mtimecmp_q[63:32];
        3'd3:    rdata_d = mtime_q[31:0];
        3'd4:    rdata_d = mtime_q[63:32];
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    mip     = '0;
    mip[11] = meip;
    mip[7]  = mtip_q;
    mip[3]  = msip_q;
    en_set  = mip & mie_i & {32{mie_global_i}};
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (|en_set) begin
          state_d = REQ;
          if (en_set[11])     cause_d = CAUSE_MEI;
          else if (en_set[3]) cause_d = CAUSE_MSI;
          else                cause_d = CAUSE_MTI;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = WAIT_CLR;
        end else if (!en_set[src_idx]) begin
          state_d = IDLE;
          cause_d = '0;
        end
      end
      WAIT_CLR: begin
        if (!mie_global_i || !mip[src_idx]) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cause_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cause_q    <= '0;
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      rdata_q    <= rdata_d;
      ready_q    <= bus_en_i;
    end
  end

  assign interrupt_o = (state_q == REQ);
  assign irq_cause_o = cause_q;
  assign bus_rdata_o = rdata_q;
  assign bus_ready_o = ready_q;

endmodule

// File: tb/tb_machine_irq_ctrl.sv
// Bench for machine_irq_ctrl: randomized register/interrupt scenarios against a simple priority/timer model.
module tb_machine_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_en, bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic        mie_global;
  logic [31:0] mie;
  logic        irq_ack;
  logic        interrupt;
  logic [31:0] irq_cause;
`ifdef MACHINE_IRQ_EXT_EN
  logic        ext_irq;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] C_MEI = 32'h8000_000B;
  localparam logic [31:0] C_MSI = 32'h8000_0003;
  localparam logic [31:0] C_MTI = 32'h8000_0007;

  machine_irq_ctrl #(.TICK_DIV(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_en_i     (bus_en),
    .bus_we_i     (bus_we),
    .bus_addr_i   (bus_addr),
    .bus_wdata_i  (bus_wdata),
    .bus_rdata_o  (bus_rdata),
    .bus_ready_o  (bus_ready),
    .mie_global_i (mie_global),
    .mie_i        (mie),
    .irq_ack_i    (irq_ack),
`ifdef MACHINE_IRQ_EXT_EN
    .ext_irq_i    (ext_irq),
`endif
    .interrupt_o  (interrupt),
    .irq_cause_o  (irq_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    step();
    total++;
    if (bus_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_ready addr=%h got=%b exp=1", a, bus_ready);
    end
    bus_en = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    step();
    d = bus_rdata;
    total++;
    if (bus_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd_ready addr=%h got=%b exp=1", a, bus_ready);
    end
    bus_en = 1'b0;
  endtask

  task automatic expect_read(input string nm, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    total++;
    if (v !== exp) begin
      bad++;
      $display("FAIL %s addr=%h got=%h exp=%h", nm, a, v, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({interrupt, irq_cause, bus_ready, bus_rdata} !== 66'b0) begin
      bad++;
      $display("FAIL reset_outputs got int=%b cause=%h rdy=%b rdata=%h exp all 0",
               interrupt, irq_cause, bus_ready, bus_rdata);
    end
    rst = 1'b0;
    step();
    expect_read("rst_cmp_lo", 5'h04, 32'hFFFF_FFFF);
    expect_read("rst_cmp_hi", 5'h08, 32'hFFFF_FFFF);
    expect_read("rst_msip", 5'h00, 32'h0);
    bus_write(5'h14, $urandom);
    bus_write(5'h18, $urandom);
    bus_write(5'h1C, $urandom);
    expect_read("unmapped_rd", 5'h14, 32'h0);
    expect_read("cmp_lo_after_unmapped_wr", 5'h04, 32'hFFFF_FFFF);
    expect_read("cmp_hi_after_unmapped_wr", 5'h08, 32'hFFFF_FFFF);
    total++;
    if (interrupt !== 1'b0 || irq_cause !== 32'h0) begin
      bad++;
      $display("FAIL rst_idle got int=%b cause=%h exp 0/0", interrupt, irq_cause);
    end
  endtask

  task automatic test_msip();
    int seen;
    mie = 32'h8; mie_global = 1'b1;
    bus_write(5'h00, $urandom | 32'h1);
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL msip_early got=%b exp=0", interrupt);
    end
    step();
    total++;
    if (interrupt !== 1'b1 || irq_cause !== C_MSI) begin
      bad++; $display("FAIL msip_req got int=%b cause=%h exp 1/%h", interrupt, irq_cause, C_MSI);
    end
    expect_read("msip_rd", 5'h00, 32'h1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL msip_ack got=%b exp=0", interrupt);
    end
    seen = 0;
    repeat (4) begin step(); if (interrupt) seen++; end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL msip_wait_clr got=%0d high cycles exp=0", seen);
    end
    mie_global = 1'b0;
    seen = 0;
    repeat (5) begin step(); if (interrupt) seen++; end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL msip_mie_off got=%0d high cycles exp=0", seen);
    end
    mie = 32'h0;
    bus_write(5'h00, $urandom & 32'hFFFF_FFFE);
    expect_read("msip_clr", 5'h00, 32'h0);
    mie_global = 1'b1;
  endtask

  task automatic test_timer();
    int unsigned cmp;
    int k;
    int rise;
    cmp = $urandom_range(6, 40);
    mie = 32'h0; mie_global = 1'b1;
    bus_write(5'h04, cmp);
    bus_write(5'h08, 32'h0);
    bus_write(5'h10, 32'h0);
    bus_write(5'h0C, 32'h0);
    step();
    k = 1;
    mie = ($urandom & ~32'h888) | 32'h80;
    rise = -1;
    while (rise < 0 && k < int'(cmp) + 20) begin
      step();
      k++;
      if (interrupt === 1'b1) rise = k;
    end
    total++;
    if (rise != int'(cmp) + 2) begin
      bad++; $display("FAIL timer_latency cmp=%0d got=%0d exp=%0d", cmp, rise, cmp + 2);
    end
    total++;
    if (irq_cause !== C_MTI) begin
      bad++; $display("FAIL timer_cause got=%h exp=%h", irq_cause, C_MTI);
    end
    mie = mie | 32'h8;
    bus_write(5'h00, 32'h1);
    step();
    total++;
    if (interrupt !== 1'b1 || irq_cause !== C_MTI) begin
      bad++; $display("FAIL no_preempt got int=%b cause=%h exp 1/%h", interrupt, irq_cause, C_MTI);
    end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL timer_ack got=%b exp=0", interrupt);
    end
    mie = 32'h0;
    bus_write(5'h00, 32'h0);
    bus_write(5'h08, 32'hFFFF_FFFF);
    bus_write(5'h04, 32'hFFFF_FFFF);
    repeat (2) step();
  endtask

  task automatic test_priority();
    logic        p_msip, p_mtip, glob, tie;
    logic [31:0] mie_v, pend, ena, exp_cause;
    int          seen;
    bus_write(5'h04, 32'h0);
    for (int it = 0; it < 10; it++) begin
      mie = 32'h0; mie_global = 1'b1;
      if (it == 0) begin
        p_msip = 1'b1; p_mtip = 1'b1; glob = 1'b1; mie_v = 32'h88;
      end else begin
        p_msip = 1'($urandom_range(0, 1));
        p_mtip = 1'($urandom_range(0, 1));
        glob   = ($urandom_range(0, 3) != 0);
        mie_v  = ($urandom & ~32'h888) | ($urandom & 32'h88);
      end
      tie = (it % 2 == 1);
      bus_write(5'h00, {31'b0, p_msip});
      bus_write(5'h08, p_mtip ? 32'h0 : 32'hFFFF_FFFF);
      repeat (2) step();
      pend = (p_msip ? 32'h8 : 32'h0) | (p_mtip ? 32'h80 : 32'h0);
      ena  = pend & mie_v & (glob ? 32'hFFFF_FFFF : 32'h0);
      exp_cause = ena[3] ? C_MSI : C_MTI;
      mie = mie_v; mie_global = glob;
      step();
      total++;
      if (interrupt !== (ena != 0) || (ena != 0 && irq_cause !== exp_cause)) begin
        bad++;
        $display("FAIL prio it=%0d mie=%h glob=%b pend=%h got int=%b cause=%h exp int=%b cause=%h",
                 it, mie_v, glob, pend, interrupt, irq_cause, (ena != 0), exp_cause);
      end
      if (ena != 0 && !tie) begin
        mie = 32'h0;
        step();
        total++;
        if (interrupt !== 1'b0 || irq_cause !== 32'h0) begin
          bad++; $display("FAIL withdraw it=%0d got int=%b cause=%h exp 0/0", it, interrupt, irq_cause);
        end
      end else if (ena != 0) begin
        mie = 32'h0; irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        mie = mie_v;
        seen = 0;
        repeat (3) begin step(); if (interrupt) seen++; end
        total++;
        if (seen != 0) begin
          bad++; $display("FAIL ack_beats_withdraw it=%0d got=%0d high cycles exp=0", it, seen);
        end
        mie_global = 1'b0;
        step();
      end else begin
        seen = 0;
        repeat (3) begin step(); if (interrupt) seen++; end
        total++;
        if (seen != 0) begin
          bad++; $display("FAIL no_enable it=%0d got=%0d high cycles exp=0", it, seen);
        end
      end
      mie = 32'h0; mie_global = 1'b1;
      step();
    end
    bus_write(5'h00, 32'h0);
    bus_write(5'h08, 32'hFFFF_FFFF);
    bus_write(5'h04, 32'hFFFF_FFFF);
    repeat (2) step();
  endtask

`ifdef MACHINE_IRQ_EXT_EN
  task automatic test_ext();
    mie = 32'h0; mie_global = 1'b1;
    bus_write(5'h04, 32'h0);
    bus_write(5'h08, 32'h0);
    bus_write(5'h00, 32'h1);
    ext_irq = 1'b1;
    repeat (4) step();
    mie = 32'h888;
    step();
    total++;
    if (interrupt !== 1'b1 || irq_cause !== C_MEI) begin
      bad++; $display("FAIL ext_prio got int=%b cause=%h exp 1/%h", interrupt, irq_cause, C_MEI);
    end
    mie = 32'h0;
    step();
    ext_irq = 1'b0;
    bus_write(5'h00, 32'h0);
    bus_write(5'h08, 32'hFFFF_FFFF);
    bus_write(5'h04, 32'hFFFF_FFFF);
    repeat (3) step();
  endtask
`endif

  task automatic test_mtime_carry();
    logic [31:0] v;
    bus_write(5'h0C, 32'hFFFF_FFFF);
    bus_write(5'h10, 32'h0);
    expect_read("carry_lo_held", 5'h0C, 32'hFFFF_FFFF);
    expect_read("carry_lo", 5'h0C, 32'h0);
    expect_read("carry_hi", 5'h10, 32'h1);
    for (int i = 0; i < 4; i++) begin
      v = $urandom & 32'h7FFF_FFFF;
      bus_write(5'h0C, v);
      expect_read("mtime_wr_rd", 5'h0C, v);
      expect_read("mtime_inc", 5'h0C, v + 32'd1);
    end
  endtask

  task automatic test_reset_mid_req();
    mie = 32'h8; mie_global = 1'b1;
    bus_write(5'h00, 32'h1);
    step();
    total++;
    if (interrupt !== 1'b1) begin
      bad++; $display("FAIL pre_rst_req got=%b exp=1", interrupt);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (interrupt !== 1'b0 || irq_cause !== 32'h0) begin
      bad++; $display("FAIL async_rst got int=%b cause=%h exp 0/0", interrupt, irq_cause);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    mie = 32'h0;
    expect_read("post_rst_msip", 5'h00, 32'h0);
    expect_read("post_rst_cmp", 5'h04, 32'hFFFF_FFFF);
  endtask

  initial begin
    rst = 1'b1; bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    mie_global = 1'b0; mie = '0; irq_ack = 1'b0;
`ifdef MACHINE_IRQ_EXT_EN
    ext_irq = 1'b0;
`endif
    test_reset();
    test_msip();
    test_timer();
    test_priority();
`ifdef MACHINE_IRQ_EXT_EN
    test_ext();
`endif
    test_mtime_carry();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/machine_irq_ctrl.md
# machine_irq_ctrl

Machine-mode interrupt source for the pipelined RV32 core. Holds the memory-mapped `mtime`/`mtimecmp`/`msip` registers and derives pending interrupts. It gates them with `mstatus.MIE` and `mie`, then raises a held `interrupt` request with its `mcause` value toward the trap-handling exception unit. The request stays up until the exception unit acknowledges trap entry. The block sits on the data-memory bus next to RAM and is decoded by the MEM-stage address decoder.

## Interface
- `TICK_DIV`, default 1: `mtime` increments once every `TICK_DIV` clk cycles; legal range 1..65535.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `bus_en`  in  1  access strobe, one cycle per access.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  5  byte offset, word aligned; low two bits are ignored.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data, valid while `bus_ready` = 1.
- `bus_ready`  out  1  one-cycle completion pulse, for reads and writes.
- `mie_global`  in  1  `mstatus.MIE` from the CSR file.
- `mie`  in  32  `mie` CSR; bits 3, 7 and 11 are used.
- `irq_ack`  in  1  pulse from the exception unit when the trap is taken.
- `interrupt`  out  1  request to the exception unit.
- `irq_cause`  out  32  `mcause` value for the current request.
- `ext_irq`  in  1  asynchronous external interrupt; present only with `MACHINE_IRQ_EXT_EN`.

## Operation
- Register map:
  - 0x00 `msip`: bit 0 is read/write, other bits read 0.
  - 0x04 `mtimecmp[31:0]`; 0x08 `mtimecmp[63:32]`.
  - 0x0C `mtime[31:0]`; 0x10 `mtime[63:32]`.
  - Other offsets read 0, and writes to them are ignored.
- Reset values:
  - `mtime` = 0, `mtimecmp` = all ones, `msip` = 0, prescaler = 0.
  - `interrupt` = 0, `irq_cause` = 0, `bus_rdata` = 0, `bus_ready` = 0.
  - State machine in IDLE.
- Prescaler counts 0..`TICK_DIV`-1; `mtime` += 1 when it wraps. The increment is a full 64-bit carry (0x0000_0000_FFFF_FFFF -> 0x0000_0001_0000_0000).
- Bus write to a `mtime` half in the same cycle as a tick: the written half takes the written value, the other half holds, and that tick is dropped.
- `mtip` is a register: `mtip` <= (`mtime` >= `mtimecmp`), unsigned 64-bit compare.
- `mip` = {`meip` at bit 11, `mtip` at bit 7, `msip` at bit 3}.
- Enabled set = `mip` & `mie` & {32{`mie_global`}}.
- Priority: MEI > MSI > MTI. Cause codes: 0x8000_000B, 0x8000_0003, 0x8000_0007.
- State machine:
  - IDLE: if the enabled set is non-zero, latch the winning cause into `irq_cause` and go to REQ.
  - REQ: `interrupt` = 1 and `irq_cause` is frozen. On `irq_ack`, go to WAIT_CLR. If the latched source is no longer enabled and no ack has arrived, withdraw: go to IDLE and clear `irq_cause` to 0. If both happen in the same cycle, `irq_ack` wins.
  - WAIT_CLR: `interrupt` = 0. Return to IDLE once `mie_global` = 0 or the latched source's `mip` bit = 0. This prevents re-requesting during the exception unit's multi-cycle `mstatus`/`mepc`/`mcause` writes.
- A higher-priority source arriving during REQ does not preempt; the frozen cause is kept.

## Timing
- Bus: access sampled at edge N; `bus_ready` = 1 and `bus_rdata` valid during cycle N+1. A write's register update is visible from edge N.
- `msip` write at edge N (enabled) -> state REQ at edge N+1 -> `interrupt` = 1 during cycle N+1.
- Timer: edge where `mtime` becomes equal to `mtimecmp` = T -> `mtip` set at T+1 -> `interrupt` = 1 after T+2.
- `irq_ack` sampled at edge A -> `interrupt` = 0 after edge A.
- `rst` asserted at any time clears all state and outputs immediately, including mid-REQ.

## Configuration
- `MACHINE_IRQ_EXT_EN` defined: the `ext_irq` port exists and passes through a 2-flop synchronizer, reset 0, to give `meip`. Latency from `ext_irq` to `interrupt` is 3 cycles.
- Not defined: there is no `ext_irq` port, `meip` is constant 0, and cause 0x8000_000B is never produced.

## Test plan
- Reset, then read 0x04 and 0x08 -> both 0xFFFF_FFFF; `interrupt` = 0 and `irq_cause` = 0 throughout.
- `mie` = 0x8, `mie_global` = 1; write `msip` = 1 -> `interrupt` = 1 one cycle after `bus_ready`, `irq_cause` = 0x8000_0003. Pulse `irq_ack` -> `interrupt` = 0 next cycle. Drop `mie_global` -> IDLE; no re-request while it stays 0.
- `TICK_DIV` = 1; write `mtimecmp` = 10 (high half 0), `mtime` = 0, `mie` = 0x80 -> `interrupt` rises two cycles after `mtime` reads 10, with `irq_cause` = 0x8000_0007.
- `msip` and `mtip` pending in the same cycle with `mie` = 0x88 -> `irq_cause` = 0x8000_0003. With the macro and `ext_irq` also high, `mie` = 0x888 -> 0x8000_000B.
- In REQ, clear `mie` to 0 before any ack -> `interrupt` = 0 next cycle and `irq_cause` = 0.
- Write `mtime` low = 0xFFFF_FFFF, high = 0 -> one tick later, reads return low 0, high 1. Assert `rst` mid-REQ -> `interrupt` = 0 immediately.
